// File: rtl/axis_rr_arb_if.sv
// AXI4-Stream style handshake bundle shared by the arbiter ports.
// DATA_W is the payload width in bits and must be a multiple of 8.
interface my_axis_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0]   tdata;
  logic [DATA_W/8-1:0] tkeep;
  logic                tlast;
  logic                tvalid;
  logic                tready;

  // Stream source side: drives payload and valid, observes ready.
  modport master (output tdata, output tkeep, output tlast, output tvalid,
                  input  tready);

  // Stream sink side: observes payload and valid, drives ready.
  modport slave  (input  tdata, input  tkeep, input  tlast, input  tvalid,
                  output tready);
endinterface

// File: rtl/axis_rr_arb.sv
// Two-input packet-level round-robin arbiter for AXI4-Stream.
// A grant is taken in IDLE and held for the whole packet; the winning
// stream is then passed straight through with no buffering. One IDLE
// cycle always separates consecutive packets, which is where arbitration
// happens. Per-source packet counters wrap silently.
module axis_rr_arb #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  my_axis_if.slave         s0_axis,
  my_axis_if.slave         s1_axis,
  my_axis_if.master        m_axis,
  output logic             busy,
  output logic             grant,
  output logic [CNT_W-1:0] pkt_cnt0,
  output logic [CNT_W-1:0] pkt_cnt1
);

  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  // Reset to 1 so that s0 wins the very first contention.
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt0_q, cnt0_d;
  logic [CNT_W-1:0]  cnt1_q, cnt1_d;

  // Payload of whichever input currently holds (or last held) the grant.
  logic [DATA_W-1:0] sel_data;
  logic [KEEP_W-1:0] sel_keep;
  logic              sel_last;
  logic              sel_valid;
  logic              pkt_end;

  // Select the granted input; only meaningful while ACTIVE.
  always_comb begin
    if (grant_q) begin
      sel_data  = s1_axis.tdata;
      sel_keep  = s1_axis.tkeep;
      sel_last  = s1_axis.tlast;
      sel_valid = s1_axis.tvalid;
    end else begin
      sel_data  = s0_axis.tdata;
      sel_keep  = s0_axis.tkeep;
      sel_last  = s0_axis.tlast;
      sel_valid = s0_axis.tvalid;
    end
  end

  // Last beat of the granted packet handed over to the sink this cycle.
  assign pkt_end = (state_q == ACTIVE) && sel_valid && m_axis.tready && sel_last;

  // State, grant and counter registers; reset forces IDLE at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
    end
  end

  // Next-state: arbitrate in IDLE, hold the grant in ACTIVE until tlast moves.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      IDLE: begin
        if (s0_axis.tvalid && s1_axis.tvalid) begin
          // Contention: hand the packet to whoever did not go last.
          grant_d = ~last_grant_q;
          state_d = ACTIVE;
        end else if (s0_axis.tvalid) begin
          grant_d = 1'b0;
          state_d = ACTIVE;
        end else if (s1_axis.tvalid) begin
          grant_d = 1'b1;
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (pkt_end) begin
          state_d      = IDLE;
          last_grant_d = grant_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet counters advance once per completed packet and wrap freely.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pkt_end) begin
      if (grant_q) cnt1_d = cnt1_q + 1'b1;
      else         cnt0_d = cnt0_q + 1'b1;
    end
  end

  // Outputs: pass-through of the granted input while ACTIVE, all quiet in IDLE.
  always_comb begin
    m_axis.tdata   = '0;
    m_axis.tkeep   = '0;
    m_axis.tlast   = 1'b0;
    m_axis.tvalid  = 1'b0;
    s0_axis.tready = 1'b0;
    s1_axis.tready = 1'b0;
    busy           = 1'b0;
    if (state_q == ACTIVE) begin
      busy          = 1'b1;
      m_axis.tdata  = sel_data;
      m_axis.tkeep  = sel_keep;
      m_axis.tlast  = sel_last;
      m_axis.tvalid = sel_valid;
      if (grant_q) s1_axis.tready = m_axis.tready;
      else         s0_axis.tready = m_axis.tready;
    end
  end

  assign grant    = grant_q;
  assign pkt_cnt0 = cnt0_q;
  assign pkt_cnt1 = cnt1_q;

endmodule

// File: tb/tb_axis_rr_arb.sv
// Self-checking bench for axis_rr_arb. Counters are built 8 bits wide so
// the wrap boundary is reachable in a short run.
module tb_axis_rr_arb;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 8;
  localparam int NPKT   = 15;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  my_axis_if #(.DATA_W(DATA_W)) s0_if ();
  my_axis_if #(.DATA_W(DATA_W)) s1_if ();
  my_axis_if #(.DATA_W(DATA_W)) m_if ();

  logic             busy, grant;
  logic [CNT_W-1:0] cnt0, cnt1;

  axis_rr_arb #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axis(s0_if), .s1_axis(s1_if), .m_axis(m_if),
    .busy(busy), .grant(grant), .pkt_cnt0(cnt0), .pkt_cnt1(cnt1)
  );

  // Source-side drive state, index 0 = s0, 1 = s1.
  logic [1:0]       sv = '0, sl = '0, sk = '1;
  logic [1:0][7:0]  sd = '0;
  logic             mr = 1'b1;
  logic [1:0]       srdy;

  assign s0_if.tvalid = sv[0];
  assign s0_if.tdata  = sd[0];
  assign s0_if.tlast  = sl[0];
  assign s0_if.tkeep  = sk[0];
  assign s1_if.tvalid = sv[1];
  assign s1_if.tdata  = sd[1];
  assign s1_if.tlast  = sl[1];
  assign s1_if.tkeep  = sk[1];
  assign m_if.tready  = mr;
  assign srdy = {s1_if.tready, s0_if.tready};

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every beat transferred on m_axis, tagged with the grant and cycle.
  typedef struct packed {
    logic       g;
    logic [7:0] d;
    logic       k;
    logic       l;
    int         c;
  } beat_t;
  beat_t cap[$];
  beat_t mon_bt;
  always @(negedge clk) begin
    if (rst_n && m_if.tvalid === 1'b1 && m_if.tready === 1'b1) begin
      mon_bt.g = grant; mon_bt.d = m_if.tdata; mon_bt.k = m_if.tkeep[0];
      mon_bt.l = m_if.tlast; mon_bt.c = cyc;
      cap.push_back(mon_bt);
    end
  end

  // Expected per-source beat streams {tlast, tdata} for the random test.
  logic [8:0] exp0[$];
  logic [8:0] exp1[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    rst_n = 1'b0; sv = '0; sl = '0; sd = '0; sk = '1; mr = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Present an n-beat packet (data base, base+1, ...) on one source, with an
  // optional run of gap_len invalid cycles after beat gap_at. Called at posedge+1.
  task automatic drive_pkt(input int src, input int n, input logic [7:0] base,
                           input int gap_at, input int gap_len);
    logic acc;
    int   bound;
    for (int b = 0; b < n; b++) begin
      sv[src] = 1'b1; sd[src] = base + 8'(b); sl[src] = (b == n - 1); sk[src] = 1'b1;
      acc = 1'b0; bound = 0;
      while (!acc) begin
        @(negedge clk); acc = srdy[src];
        @(posedge clk); #1;
        bound++;
        if (!acc && bound > 300) begin
          checks++; errors++;
          $display("FAIL drive_timeout src=%0d beat=%0d got no tready, required tready within 300 cycles", src, b);
          sv[src] = 1'b0;
          return;
        end
      end
      if (b == gap_at && gap_len > 0) begin
        sv[src] = 1'b0;
        repeat (gap_len) @(posedge clk);
        #1;
      end
    end
    sv[src] = 1'b0; sl[src] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; sv = '0; mr = 1'b1;
    #3;  // no clock edge yet: values must come from the async reset
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (grant !== 1'b0) begin errors++; $display("FAIL rst_grant got %b want 0", grant); end
    checks++; if (cnt0 !== '0) begin errors++; $display("FAIL rst_cnt0 got %0d want 0", cnt0); end
    checks++; if (cnt1 !== '0) begin errors++; $display("FAIL rst_cnt1 got %0d want 0", cnt1); end
    checks++; if (srdy !== 2'b00) begin errors++; $display("FAIL rst_tready got %b want 00", srdy); end
    checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rst_mvalid got %b want 0", m_if.tvalid); end
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_contention();
    int t0;
    logic [7:0] ed[6];
    do_reset();
    cap.delete();
    t0 = cyc;
    fork
      drive_pkt(0, 3, 8'hA0, -1, 0);
      drive_pkt(1, 3, 8'hB0, -1, 0);
    join
    ed = '{8'hA0, 8'hA1, 8'hA2, 8'hB0, 8'hB1, 8'hB2};
    checks++;
    if (cap.size() != 6) begin errors++; $display("FAIL cont_beats got %0d want 6", cap.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (cap[i].d !== ed[i] || cap[i].g !== (i >= 3) || cap[i].l !== (i % 3 == 2)) begin
          errors++;
          $display("FAIL cont_beat%0d got d=%h g=%b l=%b want d=%h g=%0d l=%0d",
                   i, cap[i].d, cap[i].g, cap[i].l, ed[i], (i >= 3), (i % 3 == 2));
        end
      end
      checks++; if (cap[0].c != t0 + 1) begin errors++; $display("FAIL cont_latency got %0d want 1", cap[0].c - t0); end
      checks++; if (cap[3].c != cap[2].c + 2) begin errors++; $display("FAIL cont_idle_gap got %0d want 2", cap[3].c - cap[2].c); end
    end
    checks++; if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin errors++; $display("FAIL cont_cnt got %0d/%0d want 1/1", cnt0, cnt1); end
  endtask

  task automatic test_single_beat();
    int t0;
    do_reset();
    cap.delete();
    t0 = cyc;
    drive_pkt(1, 1, 8'h5A, -1, 0);
    checks++;
    if (cap.size() != 1 || cap[0].d !== 8'h5A || cap[0].c != t0 + 1 || cap[0].g !== 1'b1 || cap[0].l !== 1'b1)
      begin errors++; $display("FAIL single_beat got n=%0d want one beat 5a at +1 with grant 1", cap.size()); end
    checks++; if (grant !== 1'b1) begin errors++; $display("FAIL single_grant got %b want 1", grant); end
    checks++; if (cnt1 !== 8'd1 || cnt0 !== 8'd0) begin errors++; $display("FAIL single_cnt got %0d/%0d want 0/1", cnt0, cnt1); end
    // s1 went last, so contention goes to s0; then s0 alone, so next contention goes to s1.
    fork
      drive_pkt(0, 1, 8'h10, -1, 0);
      drive_pkt(1, 1, 8'h20, -1, 0);
    join
    drive_pkt(0, 1, 8'h30, -1, 0);
    fork
      drive_pkt(0, 1, 8'h40, -1, 0);
      drive_pkt(1, 1, 8'h50, -1, 0);
    join
    checks++;
    if (cap.size() != 6) begin errors++; $display("FAIL rr_beats got %0d want 6", cap.size()); end
    else begin
      checks++; if (cap[1].d !== 8'h10 || cap[2].d !== 8'h20) begin errors++; $display("FAIL rr_after_s1 got %h,%h want 10,20", cap[1].d, cap[2].d); end
      checks++; if (cap[4].d !== 8'h50 || cap[5].d !== 8'h40) begin errors++; $display("FAIL rr_after_s0 got %h,%h want 50,40", cap[4].d, cap[5].d); end
    end
  endtask

  task automatic test_stall();
    logic       done0;
    logic [3:0] pat;
    do_reset();
    cap.delete();
    done0 = 1'b0;
    pat = 4'b1001;
    fork
      begin drive_pkt(0, 4, 8'hC0, -1, 0); done0 = 1'b1; end
      drive_pkt(1, 1, 8'hD0, -1, 0);
      begin
        int i = 0;
        mr = pat[0];
        while (!done0) begin
          @(posedge clk); #1;
          i++; mr = pat[i % 4];
        end
        mr = 1'b1;
      end
      begin
        logic [7:0] prev_d = '0;
        logic       prev_stall = 1'b0;
        while (!done0) begin
          @(negedge clk);
          if (done0) break;
          checks++; if (srdy[1] !== 1'b0) begin errors++; $display("FAIL stall_s1_tready got %b want 0", srdy[1]); end
          if (prev_stall && m_if.tvalid) begin
            checks++;
            if (m_if.tdata !== prev_d) begin errors++; $display("FAIL stall_hold got %h want %h", m_if.tdata, prev_d); end
          end
          prev_stall = m_if.tvalid && !m_if.tready;
          prev_d     = m_if.tdata;
        end
      end
    join
    checks++;
    if (cap.size() != 5) begin errors++; $display("FAIL stall_beats got %0d want 5", cap.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (cap[i].d !== 8'hC0 + 8'(i) || cap[i].g !== 1'b0)
          begin errors++; $display("FAIL stall_beat%0d got %h want %h", i, cap[i].d, 8'hC0 + 8'(i)); end
      end
      checks++; if (cap[4].d !== 8'hD0) begin errors++; $display("FAIL stall_s1 got %h want d0", cap[4].d); end
    end
    checks++; if (cnt0 !== 8'd1 || cnt1 !== 8'd1) begin errors++; $display("FAIL stall_cnt got %0d/%0d want 1/1", cnt0, cnt1); end
  endtask

  task automatic test_reset_mid();
    int   acc_n = 0, bound = 0;
    logic a;
    do_reset();
    sv[0] = 1'b1; sd[0] = 8'h40; sl[0] = 1'b0;
    while (acc_n < 2 && bound < 50) begin
      @(negedge clk); a = srdy[0];
      @(posedge clk); #1;
      bound++;
      if (a) begin acc_n++; sd[0] = 8'h40 + 8'(acc_n); end
    end
    checks++; if (acc_n != 2 || busy !== 1'b1) begin errors++; $display("FAIL rmid_setup got beats=%0d busy=%b want 2/1", acc_n, busy); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b want 0", busy); end
    checks++; if (srdy !== 2'b00 || m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rmid_quiet got rdy=%b mv=%b want 00/0", srdy, m_if.tvalid); end
    checks++; if (cnt0 !== 8'd0) begin errors++; $display("FAIL rmid_cnt0 got %0d want 0", cnt0); end
    sv = '0; sl = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cap.delete();
    drive_pkt(1, 2, 8'h70, -1, 0);
    checks++;
    if (cap.size() != 2 || cap[0].d !== 8'h70 || cap[1].d !== 8'h71)
      begin errors++; $display("FAIL rmid_restart got n=%0d want beats 70,71", cap.size()); end
    checks++; if (cnt0 !== 8'd0 || cnt1 !== 8'd1) begin errors++; $display("FAIL rmid_cnt got %0d/%0d want 0/1", cnt0, cnt1); end
  endtask

  task automatic test_wrap();
    int full = (1 << CNT_W) - 1;
    do_reset();
    for (int i = 0; i < full; i++) drive_pkt(0, 1, 8'(i), -1, 0);
    checks++; if (cnt0 !== CNT_W'(full)) begin errors++; $display("FAIL wrap_full got %0d want %0d", cnt0, full); end
    drive_pkt(0, 1, 8'hEE, -1, 0);
    checks++; if (cnt0 !== '0) begin errors++; $display("FAIL wrap_zero got %0d want 0", cnt0); end
    checks++; if (cnt1 !== '0) begin errors++; $display("FAIL wrap_cnt1 got %0d want 0", cnt1); end
  endtask

  task automatic test_gap();
    logic done0;
    int   gaps = 0;
    do_reset();
    cap.delete();
    done0 = 1'b0;
    fork
      begin drive_pkt(0, 4, 8'hE0, 1, 2); done0 = 1'b1; end
      drive_pkt(1, 2, 8'hF0, -1, 0);
      begin
        while (!done0) begin
          @(negedge clk);
          if (done0) break;
          if (busy) begin
            checks++; if (grant !== 1'b0) begin errors++; $display("FAIL gap_grant got %b want 0", grant); end
            if (!sv[0]) begin
              gaps++;
              checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL gap_mvalid got %b want 0", m_if.tvalid); end
            end
          end
        end
      end
    join
    checks++; if (gaps != 2) begin errors++; $display("FAIL gap_cycles got %0d want 2", gaps); end
    checks++;
    if (cap.size() != 6) begin errors++; $display("FAIL gap_beats got %0d want 6", cap.size()); end
    else begin
      for (int i = 0; i < 6; i++) begin
        logic [7:0] e;
        e = (i < 4) ? 8'hE0 + 8'(i) : 8'hF0 + 8'(i - 4);
        checks++;
        if (cap[i].d !== e || cap[i].g !== (i >= 4))
          begin errors++; $display("FAIL gap_beat%0d got %h/%b want %h/%0d", i, cap[i].d, cap[i].g, e, (i >= 4)); end
      end
    end
  endtask

  // Random packets on one source: random length, payload base, idle spacing
  // and an optional mid-packet valid gap. Expected beats are queued first.
  task automatic src_proc(input int src);
    for (int p = 0; p < NPKT; p++) begin
      int         len, gat, glen, idle;
      logic [7:0] base;
      len  = $urandom_range(1, 5);
      base = 8'($urandom);
      gat  = (len > 1 && $urandom_range(0, 1) == 1) ? $urandom_range(0, len - 2) : -1;
      glen = $urandom_range(1, 3);
      idle = $urandom_range(0, 3);
      for (int b = 0; b < len; b++) begin
        if (src == 0) exp0.push_back({(b == len - 1), base + 8'(b)});
        else          exp1.push_back({(b == len - 1), base + 8'(b)});
      end
      drive_pkt(src, len, base, gat, glen);
      repeat (idle) @(posedge clk);
      #0;
    end
  endtask

  task automatic test_random();
    logic d0, d1;
    int   i0 = 0, i1 = 0;
    logic in_pkt = 1'b0, cur = 1'b0;
    logic [8:0] e;
    do_reset();
    cap.delete(); exp0.delete(); exp1.delete();
    d0 = 1'b0; d1 = 1'b0;
    fork
      begin src_proc(0); d0 = 1'b1; end
      begin src_proc(1); d1 = 1'b1; end
      begin
        while (!(d0 && d1)) begin
          mr = ($urandom_range(0, 3) != 0);
          @(posedge clk); #1;
        end
        mr = 1'b1;
      end
    join
    foreach (cap[i]) begin
      if (in_pkt && cap[i].g !== cur) begin
        checks++; errors++;
        $display("FAIL rand_interleave beat%0d got src %b want src %b", i, cap[i].g, cur);
      end
      cur = cap[i].g;
      if (cur == 1'b0) begin
        e = (i0 < exp0.size()) ? exp0[i0] : 9'h1FF; i0++;
      end else begin
        e = (i1 < exp1.size()) ? exp1[i1] : 9'h1FF; i1++;
      end
      checks++;
      if ({cap[i].l, cap[i].d} !== e || cap[i].k !== 1'b1)
        begin errors++; $display("FAIL rand_beat%0d src%b got l=%b d=%h want l=%b d=%h", i, cur, cap[i].l, cap[i].d, e[8], e[7:0]); end
      in_pkt = !cap[i].l;
    end
    checks++; if (i0 != exp0.size() || i1 != exp1.size())
      begin errors++; $display("FAIL rand_count got %0d/%0d want %0d/%0d", i0, i1, exp0.size(), exp1.size()); end
    checks++; if (cnt0 !== CNT_W'(NPKT) || cnt1 !== CNT_W'(NPKT))
      begin errors++; $display("FAIL rand_pkt_cnt got %0d/%0d want %0d/%0d", cnt0, cnt1, NPKT, NPKT); end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_single_beat();
    test_stall();
    test_reset_mid();
    test_gap();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
